// File: rtl/show_scan_if.sv
// Interface between the scan driver, its debug-word read port and the display pins.
interface show_scan_if;
    logic [3:0]  sel;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  led;

    modport master (
        output sel,
        output rd_data,
        input  rd_addr,
        input  an,
        input  seg,
        input  dp,
        input  led
    );

    modport slave (
        input  sel,
        input  rd_data,
        output rd_addr,
        output an,
        output seg,
        output dp,
        output led
    );
endinterface

// File: rtl/show_scan_driver.sv
// Snapshots the debug word selected by sel and scans it as 8 hex digits onto a
// multiplexed active-low 7-segment display, with a blanking gap between digits.
module show_scan_driver #(
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned NUM_SEL   = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    show_scan_if.slave bus
);

    localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e          state_q;
    logic [3:0]      sel_q;
    logic [31:0]     snap_q;
    logic [2:0]      digit_q;
    logic [CntW-1:0] div_cnt_q;
    logic            load_pend_q;
    logic [7:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    logic            in_range;
    logic            show_end;
    logic            frame_wrap;
    logic [3:0]      nibble;

    assign in_range   = 32'(sel_q) < NUM_SEL;
    assign show_end   = (state_q == StShow) && (div_cnt_q == ShowLast);
    assign frame_wrap = show_end && (digit_q == 3'd7);
    assign nibble     = snap_q[{digit_q, 2'b00} +: 4];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBlank;
            sel_q       <= '0;
            snap_q      <= '0;
            digit_q     <= '0;
            div_cnt_q   <= '0;
            load_pend_q <= 1'b1;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            sel_q <= bus.sel;
            // An index change and a frame wrap in the same cycle merge into one pending load.
            load_pend_q <= (bus.sel != sel_q) || frame_wrap;
            if (load_pend_q) begin
                snap_q <= in_range ? bus.rd_data : 32'h0;
            end

            unique case (state_q)
                StBlank: begin
                    an_q  <= 8'hFF;
                    seg_q <= 7'h7F;
                    dp_q  <= 1'b1;
                    if (div_cnt_q == BlankLast) begin
                        div_cnt_q <= '0;
                        state_q   <= StShow;
                    end else begin
                        div_cnt_q <= div_cnt_q + CntW'(1);
                    end
                end
                StShow: begin
                    an_q  <= ~(8'b1 << digit_q);
                    seg_q <= hex7(nibble);
                    dp_q  <= in_range;
                    if (show_end) begin
                        div_cnt_q <= '0;
                        state_q   <= StBlank;
                        digit_q   <= digit_q + 3'd1;
                    end else begin
                        div_cnt_q <= div_cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.rd_addr = sel_q;
    assign bus.led     = sel_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;

endmodule

// File: tb/tb_show_scan_driver.sv
// Self-checking bench for show_scan_driver: directed scenarios plus random sel and
// memory activity, checked against an edge-count based reference model.
module tb_show_scan_driver;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned BlankCyc = 2;
    localparam int unsigned NumSel   = 13;
    localparam int unsigned Period   = ScanDiv + BlankCyc;
    localparam int unsigned Frame    = 8 * Period;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    show_scan_if bus ();
    logic [31:0] mem [16];
    assign bus.rd_data = mem[bus.rd_addr];

    show_scan_driver #(
        .SCAN_DIV (ScanDiv),
        .BLANK_CYC(BlankCyc),
        .NUM_SEL  (NumSel)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [6:0] hex_tab [16];

    // Model state: edges since reset release, index after last edge, snapshot, change flag.
    int unsigned n;
    logic [3:0]  m_selq;
    logic [31:0] m_snap;
    logic        m_changed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_selq    = 4'd0;
        m_snap    = 32'h0;
        m_changed = 1'b0;
    endtask

    // One clock edge: predict outputs from position in the scan, then compare.
    task automatic step();
        logic        blank;
        int unsigned dig;
        logic [3:0]  nb;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        load;
        logic [31:0] val;
        logic [3:0]  s;
        blank = (n % Period) < BlankCyc;
        dig   = (n / Period) % 8;
        nb    = m_snap[4*dig +: 4];
        e_an  = blank ? 8'hFF : ~(8'h01 << dig);
        e_seg = blank ? 7'h7F : hex_tab[nb];
        e_dp  = blank ? 1'b1 : (32'(m_selq) < NumSel);
        load  = (n == 0) || m_changed || (n > 0 && ((n - 1) % Frame) == Frame - 1);
        val   = (32'(m_selq) < NumSel) ? mem[m_selq] : 32'h0;
        s     = bus.sel;
        @(posedge clk);
        #1;
        check("an", bus.an, e_an);
        check("seg", bus.seg, e_seg);
        check("dp", bus.dp, e_dp);
        check("led", bus.led, s);
        check("rd_addr", bus.rd_addr, s);
        check("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
        if (load) m_snap = val;
        m_changed = (s != m_selq);
        m_selq    = s;
        n++;
    endtask

    // Startup after reset release with sel=0 and mem[0]=12345678.
    task automatic startup_directed();
        repeat (2) step();
        check("start_blank_an", bus.an, 8'hFF);
        step();
        check("digit0_an", bus.an, 8'hFE);
        check("digit0_seg", bus.seg, 7'h00);
        repeat (42) step();
        check("digit7_an", bus.an, 8'h7F);
        check("digit7_seg", bus.seg, 7'h79);
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0]  = 32'h1234_5678;
        mem[5]  = 32'hDEAD_BEEF;
        mem[13] = 32'hFFFF_FFFF;
        bus.sel = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_an", bus.an, 8'hFF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp", bus.dp, 1'b1);
        check("rst_led", bus.led, 4'd0);
        check("rst_rd_addr", bus.rd_addr, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        startup_directed();
        repeat (20) step();

        // Index change mid-digit.
        bus.sel = 4'd5;
        step();
        check("sel5_led", bus.led, 4'd5);
        repeat (100) step();

        // Out-of-range index then back in range.
        bus.sel = 4'd13;
        repeat (100) step();
        bus.sel = 4'd3;
        repeat (60) step();

        // Data change with constant index appears only after the frame wrap.
        mem[3] = 32'hA5C3_0F96;
        repeat (100) step();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bus.sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 15)] = $urandom;
            step();
        end

        // Asynchronous reset in the middle of a SHOW phase.
        bus.sel = 4'd7;
        for (int i = 0; i < 2 * Period && (n % Period) != 4; i++) step();
        check("pre_reset_show", 32'(bus.an != 8'hFF), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", bus.an, 8'hFF);
        check("async_seg", bus.seg, 7'h7F);
        check("async_dp", bus.dp, 1'b1);
        check("async_led", bus.led, 4'd0);
        bus.sel = 4'd0;
        mem[0]  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        startup_directed();
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
